// File: rtl/num_entry.sv
// Decimal number entry: edit digits with inc/next pulses, convert to binary, hand to core.
// Define NUM_ENTRY_AUTOCLR_EN to clear the digits when the core reports completion.
module num_entry #(
    parameter int NDIGITS = 4,
    parameter int VAL_W   = 14,
    parameter int POS_W   = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             BIN,
    input  logic                   ACK,
    input  logic                   RES_DONE,
    output logic [4*NDIGITS-1:0]   DIGITS,
    output logic [POS_W-1:0]       CUR_POS,
    output logic [VAL_W-1:0]       VALUE,
    output logic                   REQ,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        S_EDIT,
        S_CONVERT,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [POS_W-1:0] LAST = POS_W'(NDIGITS - 1);

    state_t             state_q, state_d;
    logic [3:0]         dig_q [NDIGITS];
    logic [3:0]         dig_d [NDIGITS];
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic [VAL_W-1:0]   acc_q, acc_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic [3:0]         conv_dig;
    logic [VAL_W-1:0]   acc10;

    always_comb begin
        conv_dig = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (POS_W'(i) == idx_q) conv_dig = dig_q[i];
        end
    end

    // acc*10 without a multiplier
    assign acc10 = (acc_q << 3) + (acc_q << 1);

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        req_d   = req_q;
        unique case (state_q)
            S_EDIT: begin
                if (BIN[0]) begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (POS_W'(i) == pos_q)
                            dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
                    end
                end else if (BIN[1]) begin
                    if (pos_q == LAST) begin
                        state_d = S_CONVERT;
                        acc_d   = '0;
                        idx_d   = '0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            S_CONVERT: begin
                acc_d = acc10 + VAL_W'(conv_dig);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    value_d = acc_d;
                    req_d   = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (ACK) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (RES_DONE) begin
                    pos_d   = '0;
                    state_d = S_EDIT;
`ifdef NUM_ENTRY_AUTOCLR_EN
                    for (int i = 0; i < NDIGITS; i++) dig_d[i] = '0;
`endif
                end
            end
            default: state_d = S_EDIT;
        endcase
        busy_d = (state_d != S_EDIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_EDIT;
            for (int i = 0; i < NDIGITS; i++) dig_q[i] <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        DIGITS = '0;
        for (int i = 0; i < NDIGITS; i++)
            DIGITS[4*(NDIGITS-1-i) +: 4] = dig_q[i];
    end

    assign CUR_POS = pos_q;
    assign VALUE   = value_q;
    assign REQ     = req_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_num_entry.sv
// Randomized bench for num_entry against a digit-array / arithmetic reference model.
module tb_num_entry;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  BIN = 2'b00;
    logic        ACK = 1'b0;
    logic        RES_DONE = 1'b0;
    logic [15:0] DIGITS;
    logic [1:0]  CUR_POS;
    logic [13:0] VALUE;
    logic        REQ;
    logic        BUSY;

    num_entry #(.NDIGITS(4), .VAL_W(14), .POS_W(2)) dut (
        .CLK(CLK), .RST(RST), .BIN(BIN), .ACK(ACK), .RES_DONE(RES_DONE),
        .DIGITS(DIGITS), .CUR_POS(CUR_POS), .VALUE(VALUE), .REQ(REQ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int md [4];
    int mpos;
    int mval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] pack();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[4*(3-i) +: 4] = 4'(md[i]);
        return r;
    endfunction

    function automatic int number();
        return md[0] * 1000 + md[1] * 100 + md[2] * 10 + md[3];
    endfunction

    task automatic pulse(input logic [1:0] b);
        BIN = b;
        tick();
        BIN = 2'b00;
    endtask

    task automatic run_number(input int target, input int hold);
        int t [4];
        int k;
        int drops;
        logic [13:0] v0;
        t[0] = target / 1000;
        t[1] = (target / 100) % 10;
        t[2] = (target / 10) % 10;
        t[3] = target % 10;
        for (int i = 0; i < 4; i++) begin
            k = (t[i] - md[i] + 10) % 10;
            repeat (k) begin
                pulse(($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01);
                md[i] = (md[i] + 1) % 10;
            end
            chk("dig_entry", DIGITS, pack());
            if (i == 1) begin
                RES_DONE = 1'b1;
                ACK = 1'b1;
                tick();
                RES_DONE = 1'b0;
                ACK = 1'b0;
                chk("resdone_in_edit_pos", CUR_POS, 1);
                chk("ack_in_edit_req", REQ, 0);
            end
            pulse(2'b10);
            if (i < 3) begin
                mpos++;
                chk("pos_next", CUR_POS, mpos);
            end
        end
        chk("busy_after_submit", BUSY, 1);
        mval = number();
        for (int c = 1; c <= 4; c++) begin
            BIN = 2'($urandom_range(0, 3));
            tick();
            BIN = 2'b00;
            chk("req_latency", REQ, (c == 4) ? 1 : 0);
        end
        chk("value", VALUE, mval);
        chk("dig_convert", DIGITS, pack());
        drops = 0;
        v0 = VALUE;
        repeat (hold) begin
            BIN = 2'($urandom_range(0, 3));
            tick();
            BIN = 2'b00;
            if (REQ !== 1'b1 || VALUE !== v0) drops++;
        end
        chk("req_hold", drops, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("req_after_ack", REQ, 0);
        chk("busy_wait", BUSY, 1);
        repeat ($urandom_range(1, 5)) begin
            BIN = 2'($urandom_range(0, 3));
            ACK = 1'($urandom_range(0, 1));
            tick();
            BIN = 2'b00;
            ACK = 1'b0;
        end
        chk("dig_wait", DIGITS, pack());
        chk("req_wait", REQ, 0);
        RES_DONE = 1'b1;
        tick();
        RES_DONE = 1'b0;
        mpos = 0;
`ifdef NUM_ENTRY_AUTOCLR_EN
        for (int i = 0; i < 4; i++) md[i] = 0;
`endif
        chk("busy_done", BUSY, 0);
        chk("pos_done", CUR_POS, 0);
        chk("dig_done", DIGITS, pack());
        chk("value_kept", VALUE, mval);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) md[i] = 0;
        mpos = 0;
        mval = 0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk("rst_digits", DIGITS, 0);
        chk("rst_pos", CUR_POS, 0);
        chk("rst_value", VALUE, 0);
        chk("rst_req", REQ, 0);
        chk("rst_busy", BUSY, 0);

        for (int n = 0; n < 10; n++) begin
            pulse(2'b01);
            md[0] = (md[0] + 1) % 10;
            chk("wrap", DIGITS, pack());
        end
        pulse(2'b11);
        md[0] = (md[0] + 1) % 10;
        chk("both_inc", DIGITS, pack());
        chk("both_pos", CUR_POS, 0);

        run_number(1234, 10);
        run_number(9999, 3);
        run_number(0, 2);
        for (int r = 0; r < 6; r++)
            run_number(int'($urandom_range(0, 9999)), int'($urandom_range(0, 8)));

        run_number(int'($urandom_range(1, 9999)), 0);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = $urandom_range(1, 9);
            repeat (k) begin
                pulse(2'b01);
                md[i] = (md[i] + 1) % 10;
            end
            pulse(2'b10);
        end
        repeat (4) tick();
        chk("pre_rst_req", REQ, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_req", REQ, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_digits", DIGITS, 0);
        chk("async_rst_pos", CUR_POS, 0);
        tick();
        RST = 1'b0;
        ACK = 1'b1;
        repeat (6) tick();
        ACK = 1'b0;
        chk("post_rst_req", REQ, 0);
        chk("post_rst_busy", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
